// File: rtl/config_loader.sv
// rtl/config_loader.sv - bitstream loader that shifts CHAIN_WORDS config beats into a LUT chain
// Optional feature: define CONFIG_LOADER_CHECKSUM_EN to add a running XOR checksum
// and a CHECK state that compares one trailer word against it.
module config_loader #(
  parameter int CONFIG_WIDTH = 8,
  parameter int CHAIN_WORDS  = 4
) (
  input  logic                    config_clk,
  input  logic                    config_rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CONFIG_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    config_en,
  output logic [CONFIG_WIDTH-1:0] config_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // Wide enough to hold CHAIN_WORDS itself; legal range keeps this between 1 and 16 bits.
  localparam int CNT_W = $clog2(CHAIN_WORDS + 1);
  // Count value seen on the acceptance that completes the load.
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHAIN_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef CONFIG_LOADER_CHECKSUM_EN
    CHECK = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_beat_cnt;
  logic                    r_config_en;
  logic [CONFIG_WIDTH-1:0] r_config_in;
  logic                    r_err;
  logic                    w_accept;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [CONFIG_WIDTH-1:0] r_csum;
`endif

  // Handshake and status flags are pure decodes of the registered state, so
  // they fall to 0 the instant reset asserts.
`ifdef CONFIG_LOADER_CHECKSUM_EN
  assign s_ready = (r_state == LOAD) || (r_state == CHECK);
`else
  assign s_ready = (r_state == LOAD);
`endif
  assign busy      = s_ready;
  assign done      = (r_state == DONE);
  assign w_accept  = s_valid && s_ready;
  assign config_en = r_config_en;
  assign config_in = r_config_in;
  assign err       = r_err;

  // Load sequencer: walks IDLE -> LOAD (-> CHECK) -> DONE, registers chain beats and error flag.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_config_en <= 1'b0;
      r_config_in <= '0;
      r_err       <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      // Shift enable is a single-cycle strobe; config_in holds between beats.
      r_config_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end
        LOAD: begin
          // Abort wins over a word presented in the same cycle.
          if (abort) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else if (w_accept) begin
            r_config_en <= 1'b1;
            r_config_in <= s_data;
            r_beat_cnt  <= r_beat_cnt + CNT_W'(1);
`ifdef CONFIG_LOADER_CHECKSUM_EN
            r_csum      <= r_csum ^ s_data;
`endif
            if (r_beat_cnt == LAST_BEAT) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
              r_state <= CHECK;
`else
              r_state <= DONE;
`endif
            end
          end
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        CHECK: begin
          // Trailer is compared, never shifted into the chain.
          if (abort) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else if (w_accept) begin
            if (s_data != r_csum) begin
              r_err <= 1'b1;
            end
            r_state <= DONE;
          end
        end
`endif
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - randomized self-checking bench for config_loader against a load-level model
module tb_config_loader;

  localparam int W  = 8;
  localparam int CW = 4;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b1;
  logic         start   = 1'b0;
  logic         abort   = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_data  = '0;
  logic         s_ready;
  logic         config_en;
  logic [W-1:0] config_in;
  logic         busy;
  logic         done;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W-1:0] mon_d[$];
  int           mon_c[$];
  int           done_c[$];

  config_loader #(.CONFIG_WIDTH(W), .CHAIN_WORDS(CW)) dut (
    .config_clk   (clk),
    .config_rst_n (rst_n),
    .start        (start),
    .abort        (abort),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .config_en    (config_en),
    .config_in    (config_in),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge E the bench sees cyc == E.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every chain beat and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (config_en) begin
      mon_d.push_back(config_in);
      mon_c.push_back(cyc);
    end
    if (done) done_c.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: random words and gaps; 1: words 0x11,0x22,.. no gaps; 2: as 1 with a 3-cycle gap before word 3.
  // abort_at: word index carrying abort (CW = the trailer), -1 for none.
  task automatic do_load(input int mode, input int abort_at, input bit bad_trl, input int max_gap);
    logic [W-1:0] w;
    logic [W-1:0] x;
    logic [W-1:0] exp_d[$];
    int           exp_c[$];
    int           exp_done;
    bit           aborted;
    int           gap;
    x        = '0;
    aborted  = 1'b0;
    exp_done = -1;
    mon_d.delete();
    mon_c.delete();
    done_c.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared_by_start", 32'(err), 32'd0);
    for (int i = 0; i < CW && !aborted; i++) begin
      if (mode == 0)                gap = $urandom_range(0, max_gap);
      else if (mode == 2 && i == 2) gap = 3;
      else                          gap = 0;
      repeat (gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
        check("busy_in_stall", 32'(busy), 32'd1);
      end
      w       = (mode == 0) ? W'($urandom) : W'(17 * (i + 1));
      s_valid = 1'b1;
      s_data  = w;
      start   = ($urandom_range(0, 3) == 0);
      abort   = (i == abort_at);
      @(posedge clk); #1;
      start   = 1'b0;
      abort   = 1'b0;
      s_valid = 1'b0;
      if (i == abort_at) begin
        aborted = 1'b1;
        check("idle_after_abort", 32'(busy), 32'd0);
      end else begin
        exp_d.push_back(w);
        exp_c.push_back(cyc);
        x        = x ^ w;
        exp_done = cyc;
      end
    end
`ifdef CONFIG_LOADER_CHECKSUM_EN
    if (!aborted) begin
      gap = (mode == 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin
        @(posedge clk); #1;
        check("busy_in_check", 32'(busy), 32'd1);
      end
      s_valid = 1'b1;
      s_data  = bad_trl ? (x ^ W'(1 << $urandom_range(0, W - 1))) : x;
      start   = ($urandom_range(0, 3) == 0);
      abort   = (abort_at == CW);
      @(posedge clk); #1;
      start   = 1'b0;
      abort   = 1'b0;
      s_valid = 1'b0;
      if (abort_at == CW) begin
        aborted = 1'b1;
        check("idle_after_abort_check", 32'(busy), 32'd0);
      end else begin
        exp_done = cyc;
      end
    end
`endif
    repeat (3) @(posedge clk);
    #1;
    check("pulse_count", 32'(mon_d.size()), 32'(exp_d.size()));
    foreach (exp_d[k]) begin
      if (k < mon_d.size()) begin
        check("beat_data", 32'(mon_d[k]), 32'(exp_d[k]));
        check("beat_cycle", 32'(mon_c[k]), 32'(exp_c[k]));
      end
    end
    check("done_count", 32'(done_c.size()), aborted ? 32'd0 : 32'd1);
    if (!aborted && done_c.size() > 0) check("done_cycle", 32'(done_c[0]), 32'(exp_done));
    check("err_final", 32'(err), aborted ? 32'd1 : 32'(CSUM && bad_trl));
    check("busy_after_load", 32'(busy), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #10;
    check("reset_config_en", 32'(config_en), 32'd0);
    check("reset_config_in", 32'(config_in), 32'd0);
    check("reset_s_ready", 32'(s_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_load(1, -1, 1'b0, 0);
    do_load(2, -1, 1'b0, 0);
    do_load(1, -1, 1'b1, 0);
    do_load(1, 2, 1'b0, 0);
    do_load(1, -1, 1'b0, 0);

    // Asynchronous reset in the middle of a load: outputs drop at once, no more beats.
    mon_d.delete();
    mon_c.delete();
    done_c.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    @(posedge clk); #1 s_data = 8'h5A;
    @(posedge clk); #1 s_data = 8'hC3;
    #5 rst_n = 1'b0;
    #1;
    check("async_rst_config_en", 32'(config_en), 32'd0);
    check("async_rst_config_in", 32'(config_in), 32'd0);
    check("async_rst_s_ready", 32'(s_ready), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 s_valid = 1'b0;
    check("rst_beats_before_reset", 32'(mon_d.size()), 32'd2);
    check("rst_no_done", 32'(done_c.size()), 32'd0);

    do_load(0, -1, 1'b0, 2);
    for (int n = 0; n < 24; n++) begin
      do_load(0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CW)) : -1,
              1'($urandom_range(0, 1)), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
